// File: rtl/iport_buffer_pkg.sv
// Shared constants for the input-port buffer.
// Status bit positions prepare a future CPU status-register read.
package iport_buffer_pkg;

  localparam int DATA_W      = 8;
  localparam int IPORT_DEPTH = 4;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_W         = 4;

  function automatic logic [ST_W-1:0] pack_status(
    input logic ovf,
    input logic udf,
    input logic ful,
    input logic emp
  );
    logic [ST_W-1:0] s;
    s               = '0;
    s[ST_OVERFLOW]  = ovf;
    s[ST_UNDERFLOW] = udf;
    s[ST_FULL]      = ful;
    s[ST_EMPTY]     = emp;
    return s;
  endfunction

endpackage

// File: rtl/iport_buffer_fifo_mem.sv
// Register array for the input-port FIFO.
// One write port, asynchronous read port; contents are never reset.
module fifo_mem
  import iport_buffer_pkg::*;
#(
  parameter int DEPTH = IPORT_DEPTH,
  parameter int WIDTH = DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iport_buffer.sv
// Input-side peripheral: buffers producer bytes for CPU input reads.
// Pointers, occupancy and sticky error flags live here.
module iport_buffer
  import iport_buffer_pkg::*;
#(
  parameter int DEPTH = IPORT_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow,
  output logic                     overflow,
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = rd_en && !empty;
  assign rd_data  = empty ? '0 : head;

  fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error event beats a clear in the same cycle.
      if (in_valid && full)  overflow <= 1'b1;
      else if (clr_flags)    overflow <= 1'b0;
      if (rd_en && empty)    underflow <= 1'b1;
      else if (clr_flags)    underflow <= 1'b0;
    end
  end

endmodule
